// File: rtl/mem_fetch_reader.sv
// Instruction fetch front end: walks a PC through the ram, buffers read words in a small
// prefetch FIFO and hands them to the decoder over valid/ready. MEM_FETCH_PERF_EN adds a stall counter.
module mem_fetch_reader #(
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic                 stop,
  input  logic                 jump,
  input  logic [ADDR_BITS-1:0] jump_addr,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic                 mem_out_en,
  output logic                 mem_write_en,
  input  logic [DATA_BITS-1:0] mem_data,
  output logic                 instr_valid,
  output logic [DATA_BITS-1:0] instr_data,
  output logic [ADDR_BITS-1:0] instr_addr,
  input  logic                 instr_ready,
  output logic                 busy
`ifdef MEM_FETCH_PERF_EN
  ,
  output logic [15:0]          perf_stall_cnt
`endif
);

  localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADDR_BITS-1:0] pc;
  logic [DATA_BITS-1:0] fifo_data [DEPTH];
  logic [ADDR_BITS-1:0] fifo_addr [DEPTH];
  logic [PTR_BITS-1:0]  wr_ptr;
  logic [PTR_BITS-1:0]  rd_ptr;
  logic [CNT_BITS-1:0]  count;
  logic                 fifo_full;
  logic                 flush;
  logic                 push;
  logic                 pop;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and read issue; stop outranks start, any control pulse suppresses the read
  always_comb begin
    state_nxt = state;
    flush     = stop | start | jump;
    fifo_full = (count == CNT_BITS'(DEPTH));
    push      = 1'b0;
    if (stop)       state_nxt = ST_IDLE;
    else if (start) state_nxt = ST_RUN;
    if (state == ST_RUN && !fifo_full && !flush) push = 1'b1;
  end

  assign pop          = instr_valid & instr_ready;
  assign mem_out_en   = push;
  assign mem_address  = pc;
  assign mem_write_en = 1'b0;
  assign busy         = (state == ST_RUN);
  assign instr_valid  = (count != '0);
  assign instr_data   = fifo_data[rd_ptr];
  assign instr_addr   = fifo_addr[rd_ptr];

  // Program counter: start reloads, jump redirects only while running, reads advance
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc <= '0;
    end else if (!stop) begin
      if (start)                        pc <= start_addr;
      else if (jump && state == ST_RUN) pc <= jump_addr;
      else if (push)                    pc <= pc + ADDR_BITS'(1);
    end
  end

  // Prefetch FIFO; a flush drops everything including a head popped in the same cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_data;
        fifo_addr[wr_ptr] <= pc;
        wr_ptr            <= wr_ptr + PTR_BITS'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_BITS'(1);
      if (push && !pop)      count <= count + CNT_BITS'(1);
      else if (!push && pop) count <= count - CNT_BITS'(1);
    end
  end

`ifdef MEM_FETCH_PERF_EN
  // Cycles spent running with a full FIFO, saturating
  always_ff @(posedge clk) begin
    if (!reset_n || start) begin
      perf_stall_cnt <= '0;
    end else if (state == ST_RUN && fifo_full && perf_stall_cnt != 16'hFFFF) begin
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_fetch_reader.sv
// Directed bench for mem_fetch_reader: vector table plus throughput/wrap and optional stall-counter sequences.
module tb_mem_fetch_reader;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [3:0] start_addr;
  logic       stop;
  logic       jump;
  logic [3:0] jump_addr;
  logic [3:0] mem_address;
  logic       mem_out_en;
  logic       mem_write_en;
  logic [7:0] mem_data;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic [3:0] instr_addr;
  logic       instr_ready;
  logic       busy;
`ifdef MEM_FETCH_PERF_EN
  logic [15:0] perf_stall_cnt;
`endif

  logic [7:0] ram [16];
  assign mem_data = ram[mem_address];

  int checks   = 0;
  int failures = 0;

  mem_fetch_reader #(.ADDR_BITS(4), .DATA_BITS(8), .DEPTH(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .start_addr   (start_addr),
    .stop         (stop),
    .jump         (jump),
    .jump_addr    (jump_addr),
    .mem_address  (mem_address),
    .mem_out_en   (mem_out_en),
    .mem_write_en (mem_write_en),
    .mem_data     (mem_data),
    .instr_valid  (instr_valid),
    .instr_data   (instr_data),
    .instr_addr   (instr_addr),
    .instr_ready  (instr_ready),
    .busy         (busy)
`ifdef MEM_FETCH_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       st;
    logic [3:0] sa;
    logic       sp;
    logic       jp;
    logic [3:0] ja;
    logic       rdy;
    logic       e_oe;
    logic [3:0] e_ad;
    logic       e_v;
    logic [7:0] e_d;
    logic [3:0] e_a;
    logic       e_busy;
    logic       chk_all;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst_n, st, input logic [3:0] sa, input logic sp, jp,
                              input logic [3:0] ja, input logic rdy, e_oe, input logic [3:0] e_ad,
                              input logic e_v, input logic [7:0] e_d, input logic [3:0] e_a,
                              input logic e_busy, chk_all);
    vec_t v;
    v.rst_n = rst_n; v.st = st; v.sa = sa; v.sp = sp; v.jp = jp; v.ja = ja; v.rdy = rdy;
    v.e_oe = e_oe; v.e_ad = e_ad; v.e_v = e_v; v.e_d = e_d; v.e_a = e_a;
    v.e_busy = e_busy; v.chk_all = chk_all;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int first_valid;
    int nwords;
    logic [3:0] exp_addr;

    for (int i = 0; i < 16; i++) ram[i] = 8'(i + 16);

    //             rst st sa  sp jp ja  rdy| oe ad  v  d      a   busy all
    vecs[0]  = mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 8'h00, 4'h0, 0, 1);
    vecs[1]  = mk(1, 1, 4'h0, 0, 0, 4'h0, 1, 0, 4'h0, 0, 8'h00, 4'h0, 0, 0);
    vecs[2]  = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 1, 4'h0, 0, 8'h00, 4'h0, 1, 0);
    vecs[3]  = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 1, 4'h1, 1, 8'h10, 4'h0, 1, 0);
    vecs[4]  = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 1, 4'h2, 1, 8'h11, 4'h1, 1, 0);
    vecs[5]  = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 1, 4'h3, 1, 8'h12, 4'h2, 1, 0);
    vecs[6]  = mk(1, 1, 4'h0, 0, 0, 4'h0, 0, 0, 4'h4, 1, 8'h13, 4'h3, 1, 0);
    vecs[7]  = mk(1, 0, 4'h0, 0, 0, 4'h0, 0, 1, 4'h0, 0, 8'h00, 4'h0, 1, 0);
    vecs[8]  = mk(1, 0, 4'h0, 0, 0, 4'h0, 0, 1, 4'h1, 1, 8'h10, 4'h0, 1, 0);
    vecs[9]  = mk(1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h2, 1, 8'h10, 4'h0, 1, 0);
    vecs[10] = mk(1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h2, 1, 8'h10, 4'h0, 1, 0);
    vecs[11] = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 0, 4'h2, 1, 8'h10, 4'h0, 1, 0);
    vecs[12] = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 1, 4'h2, 1, 8'h11, 4'h1, 1, 0);
    vecs[13] = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 1, 4'h3, 1, 8'h12, 4'h2, 1, 0);
    vecs[14] = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 1, 4'h4, 1, 8'h13, 4'h3, 1, 0);
    vecs[15] = mk(1, 0, 4'h0, 0, 1, 4'hC, 1, 0, 4'h5, 1, 8'h14, 4'h4, 1, 0);
    vecs[16] = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 1, 4'hC, 0, 8'h00, 4'h0, 1, 0);
    vecs[17] = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 1, 4'hD, 1, 8'h1C, 4'hC, 1, 0);
    vecs[18] = mk(1, 1, 4'hE, 0, 0, 4'h0, 1, 0, 4'hE, 1, 8'h1D, 4'hD, 1, 0);
    vecs[19] = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 1, 4'hE, 0, 8'h00, 4'h0, 1, 0);
    vecs[20] = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 1, 4'hF, 1, 8'h1E, 4'hE, 1, 0);
    vecs[21] = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 1, 4'h0, 1, 8'h1F, 4'hF, 1, 0);
    vecs[22] = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 1, 4'h1, 1, 8'h10, 4'h0, 1, 0);
    vecs[23] = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 1, 4'h2, 1, 8'h11, 4'h1, 1, 0);
    vecs[24] = mk(1, 0, 4'h0, 1, 0, 4'h0, 1, 0, 4'h3, 1, 8'h12, 4'h2, 1, 0);
    vecs[25] = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 0, 4'h3, 0, 8'h00, 4'h0, 0, 0);
    vecs[26] = mk(1, 1, 4'h7, 1, 0, 4'h0, 1, 0, 4'h3, 0, 8'h00, 4'h0, 0, 0);
    vecs[27] = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 0, 4'h3, 0, 8'h00, 4'h0, 0, 0);
    vecs[28] = mk(1, 0, 4'h0, 0, 1, 4'h9, 1, 0, 4'h3, 0, 8'h00, 4'h0, 0, 0);
    vecs[29] = mk(1, 0, 4'h0, 0, 0, 4'h0, 1, 0, 4'h3, 0, 8'h00, 4'h0, 0, 0);
    vecs[30] = mk(1, 1, 4'h8, 0, 0, 4'h0, 0, 0, 4'h3, 0, 8'h00, 4'h0, 0, 0);
    vecs[31] = mk(1, 0, 4'h0, 0, 0, 4'h0, 0, 1, 4'h8, 0, 8'h00, 4'h0, 1, 0);
    vecs[32] = mk(0, 0, 4'h0, 0, 0, 4'h0, 0, 1, 4'h9, 1, 8'h18, 4'h8, 1, 0);
    vecs[33] = mk(1, 0, 4'h0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 8'h00, 4'h0, 0, 1);

    reset_n = 1'b0; start = 1'b0; start_addr = '0; stop = 1'b0;
    jump = 1'b0; jump_addr = '0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Inputs change on the falling edge; outputs sampled 1 time unit later
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset_n = vecs[i].rst_n; start = vecs[i].st; start_addr = vecs[i].sa;
      stop = vecs[i].sp; jump = vecs[i].jp; jump_addr = vecs[i].ja;
      instr_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d mem_out_en", i), 32'(mem_out_en), 32'(vecs[i].e_oe));
      chk($sformatf("v%0d mem_address", i), 32'(mem_address), 32'(vecs[i].e_ad));
      chk($sformatf("v%0d mem_write_en", i), 32'(mem_write_en), 32'd0);
      chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].e_v));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      if (vecs[i].e_v || vecs[i].chk_all) begin
        chk($sformatf("v%0d instr_data", i), 32'(instr_data), 32'(vecs[i].e_d));
        chk($sformatf("v%0d instr_addr", i), 32'(instr_addr), 32'(vecs[i].e_a));
      end
    end

    // Streaming at one word per cycle across the address wrap
    @(negedge clk);
    reset_n = 1'b1; start = 1'b1; start_addr = 4'h0; stop = 1'b0; jump = 1'b0;
    instr_ready = 1'b1;
    first_valid = -1;
    nwords = 0;
    exp_addr = 4'h0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (instr_valid && instr_ready) begin
        if (first_valid < 0) first_valid = i;
        chk($sformatf("stream%0d addr", nwords), 32'(instr_addr), 32'(exp_addr));
        chk($sformatf("stream%0d data", nwords), 32'(instr_data), 32'(8'(exp_addr) + 8'h10));
        exp_addr = exp_addr + 4'h1;
        nwords++;
      end
    end
    chk("stream first_valid cycle", 32'(first_valid), 32'd1);
    chk("stream word count", 32'(nwords), 32'd19);

`ifdef MEM_FETCH_PERF_EN
    // Stall counter: cleared by start, then ten full cycles after the two fill cycles
    @(negedge clk);
    start = 1'b1; start_addr = 4'h0; instr_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("perf cleared on start", 32'(perf_stall_cnt), 32'd0);
    repeat (12) @(negedge clk);
    #1;
    chk("perf stall count", 32'(perf_stall_cnt), 32'd10);
    chk("perf stalled read", 32'(mem_out_en), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    chk("perf cleared on reset", 32'(perf_stall_cnt), 32'd0);
    reset_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
